// File: rtl/matrix_scan_ctrl_if.sv
// Panel-side bundle of the matrix scan controller: tick strobe in, panel and framebuffer addressing out.
interface matrix_scan_ctrl_if #(
    parameter int ROW_ADDR_WIDTH = 4,
    parameter int COL_ADDR_WIDTH = 6
);
    logic                      tick;
    logic                      matrix_clk;
    logic                      matrix_lat;
    logic                      matrix_oe_n;
    logic [ROW_ADDR_WIDTH-1:0] row_addr;
    logic [COL_ADDR_WIDTH-1:0] fb_col;
    logic [ROW_ADDR_WIDTH-1:0] fb_row;
    logic [2:0]                fb_plane;
    logic                      frame_start;

    modport master (
        input  tick,
        output matrix_clk, matrix_lat, matrix_oe_n, row_addr,
        output fb_col, fb_row, fb_plane, frame_start
    );

    modport slave (
        output tick,
        input  matrix_clk, matrix_lat, matrix_oe_n, row_addr,
        input  fb_col, fb_row, fb_plane, frame_start
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// LED matrix row scan controller: shift, blank, latch, display per row, advanced only by tick.
// Optional binary-coded modulation across bitplanes is enabled by defining SCAN_BCM_EN.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// S_SHIFT   | clock COLS columns into the panel, two ticks per column
// S_BLANK   | one tick with outputs disabled before latching
// S_LATCH   | one tick latch strobe; row_addr takes the shifted row
// S_DISPLAY | outputs enabled for the plane's on-time, then next plane/row
module matrix_scan_ctrl #(
    parameter int COLS           = 64,
    parameter int ROW_ADDR_WIDTH = 4,
    parameter int COL_ADDR_WIDTH = 6,
    parameter int PLANES         = 8,
    parameter int ON_TIME_BASE   = 4
) (
    input  logic                clk_in,
    input  logic                reset_n,
    matrix_scan_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2((ON_TIME_BASE << (PLANES - 1)) + 1);
    localparam logic [COL_ADDR_WIDTH-1:0] COL_LAST = COL_ADDR_WIDTH'(COLS - 1);
    localparam logic [ROW_ADDR_WIDTH-1:0] ROW_LAST = {ROW_ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_SHIFT   = 2'd0,
        S_BLANK   = 2'd1,
        S_LATCH   = 2'd2,
        S_DISPLAY = 2'd3
    } state_t;

    state_t                    state_q, state_nxt;
    logic                      phase_q, phase_nxt;
    logic [COL_ADDR_WIDTH-1:0] col_q, col_nxt;
    logic [ROW_ADDR_WIDTH-1:0] row_q, row_nxt;
    logic [ROW_ADDR_WIDTH-1:0] row_addr_q, row_addr_nxt;
    logic [CNT_W-1:0]          cnt_q, cnt_nxt;
    logic                      frame_nxt;
    logic                      mclk_q, mclk_nxt;
    logic                      lat_q, lat_nxt;
    logic                      oe_n_q, oe_n_nxt;
    logic                      frame_start_q;

`ifdef SCAN_BCM_EN
    localparam logic [2:0] PLANE_LAST = 3'(PLANES - 1);
    logic [2:0] plane_q, plane_nxt;
`endif

    always_comb begin
        state_nxt    = state_q;
        phase_nxt    = phase_q;
        col_nxt      = col_q;
        row_nxt      = row_q;
        row_addr_nxt = row_addr_q;
        cnt_nxt      = cnt_q;
        frame_nxt    = 1'b0;
`ifdef SCAN_BCM_EN
        plane_nxt    = plane_q;
`endif
        unique case (state_q)
            S_SHIFT: begin
                if (!phase_q) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_nxt   = '0;
                        state_nxt = S_BLANK;
                    end else begin
                        col_nxt = col_q + 1'b1;
                    end
                end
            end
            S_BLANK: state_nxt = S_LATCH;
            S_LATCH: begin
                state_nxt    = S_DISPLAY;
                row_addr_nxt = row_q;
                // Down-counter preset to on-time minus one; exit on terminal count zero.
`ifdef SCAN_BCM_EN
                cnt_nxt = (CNT_W'(ON_TIME_BASE) << plane_q) - 1'b1;
`else
                cnt_nxt = CNT_W'(ON_TIME_BASE - 1);
`endif
            end
            S_DISPLAY: begin
                if (cnt_q == '0) begin
                    state_nxt = S_SHIFT;
`ifdef SCAN_BCM_EN
                    if (plane_q == PLANE_LAST) begin
                        plane_nxt = '0;
                        row_nxt   = row_q + 1'b1;
                        frame_nxt = (row_q == ROW_LAST);
                    end else begin
                        plane_nxt = plane_q + 3'd1;
                    end
`else
                    row_nxt   = row_q + 1'b1;
                    frame_nxt = (row_q == ROW_LAST);
`endif
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: state_nxt = S_SHIFT;
        endcase

        // Panel pins are registered from the state being entered.
        mclk_nxt = (state_nxt == S_SHIFT) && phase_nxt;
        lat_nxt  = (state_nxt == S_LATCH);
        oe_n_nxt = (state_nxt != S_DISPLAY);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_SHIFT;
            phase_q       <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            row_addr_q    <= '0;
            cnt_q         <= '0;
            mclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            oe_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
`ifdef SCAN_BCM_EN
            plane_q       <= '0;
`endif
        end else begin
            // Single clk_in pulse even if the next tick is several cycles away.
            frame_start_q <= bus.tick && frame_nxt;
            if (bus.tick) begin
                state_q    <= state_nxt;
                phase_q    <= phase_nxt;
                col_q      <= col_nxt;
                row_q      <= row_nxt;
                row_addr_q <= row_addr_nxt;
                cnt_q      <= cnt_nxt;
                mclk_q     <= mclk_nxt;
                lat_q      <= lat_nxt;
                oe_n_q     <= oe_n_nxt;
`ifdef SCAN_BCM_EN
                plane_q    <= plane_nxt;
`endif
            end
        end
    end

    assign bus.matrix_clk  = mclk_q;
    assign bus.matrix_lat  = lat_q;
    assign bus.matrix_oe_n = oe_n_q;
    assign bus.row_addr    = row_addr_q;
    assign bus.fb_col      = col_q;
    assign bus.fb_row      = row_q;
    assign bus.frame_start = frame_start_q;
`ifdef SCAN_BCM_EN
    assign bus.fb_plane    = plane_q;
`else
    assign bus.fb_plane    = 3'd0;
`endif

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: per-tick expected output table built from the scan rules, random/alternating tick, mid-display reset.
module tb_matrix_scan_ctrl;

    localparam int COLS   = 4;
    localparam int RW     = 1;
    localparam int CW     = 2;
    localparam int PLANES = 2;
    localparam int BASE   = 2;
    localparam int DEPTH  = 1024;
`ifdef SCAN_BCM_EN
    localparam int NPLANES     = PLANES;
    localparam int FRAME_TICKS = 52;
`else
    localparam int NPLANES     = 1;
    localparam int FRAME_TICKS = 24;
`endif

    typedef struct packed {
        logic          mclk;
        logic          lat;
        logic          oe_n;
        logic [RW-1:0] row_addr;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic [2:0]    plane;
        logic          fs;
    } obs_t;

    logic clk_in = 1'b0;
    logic reset_n = 1'b0;

    matrix_scan_ctrl_if #(.ROW_ADDR_WIDTH(RW), .COL_ADDR_WIDTH(CW)) bus ();

    matrix_scan_ctrl #(
        .COLS(COLS), .ROW_ADDR_WIDTH(RW), .COL_ADDR_WIDTH(CW),
        .PLANES(PLANES), .ON_TIME_BASE(BASE)
    ) dut (
        .clk_in(clk_in),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    obs_t model [DEPTH];
    int   n_model;
    int   k;
    int   checks = 0;
    int   errors = 0;
    int   fs_ticks[$];
    obs_t obs, exp_v;

    function automatic void push(input obs_t e);
        if (n_model < DEPTH) model[n_model] = e;
        n_model++;
    endfunction

    // Expected panel state after each tick, written as the row/plane/column schedule itself.
    function automatic void build_model();
        obs_t e;
        logic [RW-1:0] ra;
        ra = '0;
        n_model = 0;
        for (int f = 0; n_model < DEPTH; f++) begin
            for (int r = 0; r < (1 << RW); r++) begin
                for (int p = 0; p < NPLANES; p++) begin
                    for (int c = 0; c < COLS; c++) begin
                        e = '{1'b0, 1'b0, 1'b1, ra, CW'(c), RW'(r), 3'(p),
                              (f > 0 && r == 0 && p == 0 && c == 0)};
                        push(e);
                        e = '{1'b1, 1'b0, 1'b1, ra, CW'(c), RW'(r), 3'(p), 1'b0};
                        push(e);
                    end
                    e = '{1'b0, 1'b0, 1'b1, ra, CW'(0), RW'(r), 3'(p), 1'b0};
                    push(e);
                    e = '{1'b0, 1'b1, 1'b1, ra, CW'(0), RW'(r), 3'(p), 1'b0};
                    push(e);
                    ra = RW'(r);
                    for (int d = 0; d < (BASE << p); d++) begin
                        e = '{1'b0, 1'b0, 1'b0, ra, CW'(0), RW'(r), 3'(p), 1'b0};
                        push(e);
                    end
                end
            end
        end
    endfunction

    function automatic obs_t sample();
        return '{bus.matrix_clk, bus.matrix_lat, bus.matrix_oe_n, bus.row_addr,
                 bus.fb_col, bus.fb_row, bus.fb_plane, bus.frame_start};
    endfunction

    task automatic step(input logic t, input string tag);
        @(negedge clk_in);
        bus.tick = t;
        @(posedge clk_in);
        #1;
        if (t) k++;
        if (k >= DEPTH) k = DEPTH - 1;
        exp_v = model[k];
        exp_v.fs = t & model[k].fs;
        obs = sample();
        if (obs.fs) fs_ticks.push_back(k);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        bus.tick = 1'b1;
        reset_n = 1'b0;
        @(posedge clk_in);
        #1;
        exp_v = model[0];
        exp_v.fs = 1'b0;
        obs = sample();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL reset_state observed=%h expected=%h", obs, exp_v);
        end
        @(negedge clk_in);
        bus.tick = 1'b0;
        reset_n = 1'b1;
        k = 0;
        fs_ticks.delete();
    endtask

    initial begin
        int kr;
        bus.tick = 1'b0;
        build_model();
        k = 0;

        // Continuous tick: two full frames plus margin.
        repeat (3) @(posedge clk_in);
        do_reset();
        for (int i = 0; i < 2 * FRAME_TICKS + 12; i++) step(1'b1, "continuous");
        checks++;
        assert (fs_ticks.size() === 2) else begin
            errors++;
            $error("FAIL frame_start_count observed=%0d expected=%0d", fs_ticks.size(), 2);
        end
        if (fs_ticks.size() >= 2) begin
            checks++;
            assert (fs_ticks[0] === FRAME_TICKS) else begin
                errors++;
                $error("FAIL frame_start_first observed=%0d expected=%0d", fs_ticks[0], FRAME_TICKS);
            end
            checks++;
            assert (fs_ticks[1] - fs_ticks[0] === FRAME_TICKS) else begin
                errors++;
                $error("FAIL frame_start_period observed=%0d expected=%0d",
                       fs_ticks[1] - fs_ticks[0], FRAME_TICKS);
            end
        end

        // Alternating tick: same sequence at half rate, frozen on idle cycles.
        do_reset();
        for (int i = 0; i < 2 * FRAME_TICKS + 8; i++) step(i[0] == 1'b0, "alternate");

        // Random tick pattern.
        do_reset();
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), "random");

        // Reset asserted mid-display of row 1 aborts the row asynchronously.
        kr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (kr == 0 && model[i].row == RW'(1) && !model[i].oe_n) kr = i + 1;
        end
        do_reset();
        while (k < kr) step(1'b1, "pre_abort");
        #2;
        reset_n = 1'b0;
        #1;
        exp_v = model[0];
        exp_v.fs = 1'b0;
        obs = sample();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL async_abort observed=%h expected=%h", obs, exp_v);
        end
        @(negedge clk_in);
        bus.tick = 1'b0;
        reset_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) step(1'b1, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter COLS, default 64, columns shifted per row; COLS >= 2.
REQ-002 Parameter ROW_ADDR_WIDTH, default 4, panel row address width; rows = 2**ROW_ADDR_WIDTH.
REQ-003 Parameter COL_ADDR_WIDTH, default 6, width of fb_col; 2**COL_ADDR_WIDTH >= COLS.
REQ-004 Parameter PLANES, default 8, BCM bitplanes per row (used only when SCAN_BCM_EN is defined).
REQ-005 Parameter ON_TIME_BASE, default 4, display ticks for plane 0; ON_TIME_BASE >= 1.
REQ-006 clk_in  input  1  single clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 tick  input  1  advance strobe, one clk_in cycle per divided-clock tick; all state advances only when tick=1.
REQ-009 matrix_clk  output  1  panel shift clock.
REQ-010 matrix_lat  output  1  panel latch strobe.
REQ-011 matrix_oe_n  output  1  panel output enable, active-low.
REQ-012 row_addr  output  ROW_ADDR_WIDTH  row currently displayed.
REQ-013 fb_col  output  COL_ADDR_WIDTH  framebuffer column being shifted.
REQ-014 fb_row  output  ROW_ADDR_WIDTH  framebuffer row being shifted.
REQ-015 fb_plane  output  3  bitplane being shifted; always 0 when SCAN_BCM_EN is undefined.
REQ-016 frame_start  output  1  one-clk_in pulse at start of each new frame.

Function
REQ-017 FSM states SHIFT, BLANK, LATCH, DISPLAY; transitions evaluated only on tick=1; tick=0 holds every register and output.
REQ-018 SHIFT: two ticks per column; phase 0 matrix_clk=0 with fb_col valid, phase 1 matrix_clk=1; fb_col increments after phase 1.
REQ-019 After phase 1 of column COLS-1: fb_col wraps to 0, state -> BLANK.
REQ-020 BLANK: one tick, matrix_oe_n=1, matrix_clk=0; -> LATCH.
REQ-021 LATCH: one tick, matrix_lat=1, matrix_oe_n=1; row_addr loaded with fb_row on exit; -> DISPLAY.
REQ-022 DISPLAY: matrix_oe_n=0 for exactly ON_TIME_BASE << fb_plane ticks (ON_TIME_BASE ticks when SCAN_BCM_EN undefined); then -> SHIFT.
REQ-023 matrix_oe_n=1 in all states except DISPLAY; matrix_lat=1 only in LATCH.
REQ-024 On DISPLAY exit: fb_plane increments; on wrap from PLANES-1 to 0, fb_row increments modulo 2**ROW_ADDR_WIDTH.
REQ-025 frame_start=1 for one clk_in cycle on the DISPLAY->SHIFT transition where fb_row and fb_plane both wrap to 0; never asserted after reset alone.
REQ-026 Display counter width sized to hold ON_TIME_BASE << (PLANES-1) without overflow.
REQ-027 Outputs registered; no combinational path from tick to any output.

Reset
REQ-028 reset_n=0 asynchronously forces: state SHIFT phase 0, matrix_clk=0, matrix_lat=0, matrix_oe_n=1, row_addr=0, fb_col=0, fb_row=0, fb_plane=0, frame_start=0, display counter=0.
REQ-029 Reset asserted mid-row (any state) aborts the row; first tick after release begins column 0 of row 0 plane 0.

Configuration
REQ-030 Macro SCAN_BCM_EN: defined -> PLANES bitplanes per row, DISPLAY length ON_TIME_BASE << fb_plane.
REQ-031 SCAN_BCM_EN undefined -> single plane, fb_plane tied 0, fb_row increments on every DISPLAY exit, DISPLAY length ON_TIME_BASE.

Verification (COLS=4, ROW_ADDR_WIDTH=1, PLANES=2, ON_TIME_BASE=2, tick=1 continuously unless stated)
REQ-032 Release reset -> 4 matrix_clk rising edges, fb_col 0,1,2,3, then oe_n=1 for 2 ticks, lat=1 on tick 10 only, oe_n=0 for ticks 11-12.
REQ-033 SCAN_BCM_EN defined -> plane 1 DISPLAY lasts 4 ticks; row period 12+14 ticks; frame_start pulses every 52 ticks; row_addr sequence 0,0,1,1.
REQ-034 SCAN_BCM_EN undefined -> fb_plane stays 0, DISPLAY 2 ticks, frame_start every 24 ticks.
REQ-035 tick toggling 1/0 every cycle -> identical output sequence at half rate; outputs constant while tick=0.
REQ-036 Assert reset_n=0 during DISPLAY of row 1 -> oe_n=1 and all addresses 0 same cycle; restart matches REQ-032 exactly.
